// File: rtl/srci_dbnc_n.sv
// rtl/srci_dbnc_n.sv - N-channel protection input debounce, event latch and first-fault capture
module srci_dbnc_n #(
    parameter int NCH  = 7,
    parameter int CNTW = 8,
    parameter int SYNC = 2,
    parameter int IDXW = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NCH-1:0]  i_srci,
    input  logic [NCH-1:0]  i_en,
    input  logic [NCH-1:0]  i_pol,
    input  logic [NCH-1:0]  i_latch,
    input  logic            i_tick,
    input  logic [CNTW-1:0] i_thr_a,
    input  logic [CNTW-1:0] i_thr_d,
    input  logic [NCH-1:0]  i_clr,
    output logic [NCH-1:0]  o_sta,
    output logic [NCH-1:0]  o_evt,
    output logic            o_irq,
    output logic [IDXW-1:0] o_first,
    output logic            o_first_vld
);

    logic [NCH-1:0]  r_sync [SYNC];
    logic [NCH-1:0]  r_s;
    logic [NCH-1:0]  r_sta;
    logic [NCH-1:0]  r_sta_q;
    logic [NCH-1:0]  r_evt;
    logic [CNTW-1:0] r_cnt [NCH];
    logic [IDXW-1:0] r_first;
    logic            r_first_vld;

    logic [NCH-1:0]  w_evt_nxt;
    logic [NCH-1:0]  w_set;
    logic [IDXW-1:0] w_first_idx;

    // Polarity is applied in a registered stage after the synchroniser chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC; k++) r_sync[k] <= '0;
            r_s <= '0;
        end else begin
            r_sync[0] <= i_srci;
            for (int k = 1; k < SYNC; k++) r_sync[k] <= r_sync[k-1];
            r_s <= r_sync[SYNC-1] ^ i_pol;
        end
    end

    // Counter saturates at the threshold compare, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sta <= '0;
            for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!i_en[i]) begin
                    r_sta[i] <= 1'b0;
                    r_cnt[i] <= '0;
                end else if (r_s[i] == r_sta[i]) begin
                    r_cnt[i] <= '0;
                end else if (i_tick) begin
                    if (r_cnt[i] >= (r_sta[i] ? i_thr_d : i_thr_a)) begin
                        r_sta[i] <= ~r_sta[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_evt_nxt   = '0;
        w_first_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!i_en[i])
                w_evt_nxt[i] = 1'b0;
            else if (i_latch[i])
                w_evt_nxt[i] = (r_evt[i] & ~i_clr[i]) | (r_sta[i] & ~r_sta_q[i]);
            else
                w_evt_nxt[i] = r_sta[i];
        end
        w_set = w_evt_nxt & ~r_evt;
        // Descending scan so the lowest setting index is the one left standing.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_set[i]) w_first_idx = IDXW'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sta_q     <= '0;
            r_evt       <= '0;
            r_first     <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_sta_q <= r_sta;
            r_evt   <= w_evt_nxt;
            if ((!r_first_vld || (r_evt == '0)) && (w_set != '0)) begin
                r_first     <= w_first_idx;
                r_first_vld <= 1'b1;
            end else if (r_evt == '0) begin
                r_first_vld <= 1'b0;
            end
        end
    end

    assign o_sta       = r_sta;
    assign o_evt       = r_evt;
    assign o_irq       = |r_evt;
    assign o_first     = r_first;
    assign o_first_vld = r_first_vld;

endmodule

// File: tb/tb_srci_dbnc_n.sv
// tb/tb_srci_dbnc_n.sv - scoreboard bench for srci_dbnc_n with directed vectors
module tb_srci_dbnc_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] srci, en, pol, latch, clr;
    logic       tick;
    logic [7:0] thr_a, thr_d;
    logic [6:0] sta, evt;
    logic       irq;
    logic [2:0] first;
    logic       first_vld;

    srci_dbnc_n #(.NCH(7), .CNTW(8), .SYNC(2), .IDXW(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_srci(srci), .i_en(en), .i_pol(pol),
        .i_latch(latch), .i_tick(tick), .i_thr_a(thr_a), .i_thr_d(thr_d),
        .i_clr(clr), .o_sta(sta), .o_evt(evt), .o_irq(irq), .o_first(first),
        .o_first_vld(first_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         id;
        logic [6:0] sta;
        logic [6:0] evt;
        logic [2:0] first;
        logic       fv;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    int   ph = 0;
    bit   tick_all = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [18:0] act, req;
            e = q.pop_front();
            act = {sta, evt, irq, first, first_vld};
            req = {e.sta, e.evt, |e.evt, e.first, e.fv};
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL chk%0d missed at cycle %0d (due %0d)", e.id, cyc, e.cyc);
            end else if (act !== req) begin
                errors++;
                $display("FAIL chk%0d cycle %0d sta/evt/irq/first/vld got %h/%h/%b/%0d/%b want %h/%h/%b/%0d/%b",
                         e.id, cyc, sta, evt, irq, first, first_vld,
                         e.sta, e.evt, |e.evt, e.first, e.fv);
            end
        end
    end

    task automatic mark();
        base = cyc;
    endtask

    // k is the edge index counted from the last mark(): edge 0 is the first edge after it.
    task automatic expect_at(input int k, input logic [6:0] s, input logic [6:0] ev,
                             input logic [2:0] f, input logic fv, input int id);
        exp_t e;
        e.cyc = base + 1 + k;
        e.id = id;
        e.sta = s;
        e.evt = ev;
        e.first = f;
        e.fv = fv;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            tick = tick_all ? 1'b1 : (ph == 3);
            ph = (ph + 1) % 4;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int id);
        srci = '0; en = 7'h7F; pol = '0; latch = '0; clr = '0;
        thr_a = 8'd3; thr_d = 8'd3; tick_all = 1'b1; ph = 0;
        rst = 1'b1;
        mark();
        expect_at(1, 7'h00, 7'h00, 3'd0, 1'b0, id);
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0;
        srci = '0; en = '0; pol = '0; latch = '0; clr = '0; thr_a = '0; thr_d = '0;
        @(posedge clk);
        #1;

        // Ch2 assert, T=3: sta at edge 6, evt/first at edge 7.
        do_reset(10);
        mark();
        srci = 7'h04;
        expect_at(5, 7'h00, 7'h00, 3'd0, 1'b0, 11);
        expect_at(6, 7'h04, 7'h00, 3'd0, 1'b0, 12);
        expect_at(7, 7'h04, 7'h04, 3'd2, 1'b1, 13);
        step(9);

        // Ch0 short glitch then a long pulse.
        do_reset(20);
        mark();
        srci = 7'h01;
        expect_at(5, 7'h00, 7'h00, 3'd0, 1'b0, 21);
        expect_at(8, 7'h00, 7'h00, 3'd0, 1'b0, 22);
        step(3);
        srci = 7'h00;
        step(6);
        mark();
        srci = 7'h01;
        expect_at(5,  7'h00, 7'h00, 3'd0, 1'b0, 23);
        expect_at(6,  7'h01, 7'h00, 3'd0, 1'b0, 24);
        expect_at(7,  7'h01, 7'h01, 3'd0, 1'b1, 25);
        expect_at(10, 7'h01, 7'h01, 3'd0, 1'b1, 26);
        expect_at(11, 7'h00, 7'h01, 3'd0, 1'b1, 27);
        expect_at(12, 7'h00, 7'h00, 3'd0, 1'b1, 28);
        expect_at(13, 7'h00, 7'h00, 3'd0, 1'b0, 29);
        step(5);
        srci = 7'h00;
        step(10);

        // Ch4 sticky: hold after release, clear, then clear colliding with set.
        do_reset(30);
        latch = 7'h10;
        thr_d = 8'd0;
        mark();
        srci = 7'h10;
        expect_at(5,  7'h00, 7'h00, 3'd0, 1'b0, 31);
        expect_at(6,  7'h10, 7'h00, 3'd0, 1'b0, 32);
        expect_at(7,  7'h10, 7'h10, 3'd4, 1'b1, 33);
        step(8);
        srci = 7'h00;
        expect_at(10, 7'h10, 7'h10, 3'd4, 1'b1, 34);
        expect_at(12, 7'h00, 7'h10, 3'd4, 1'b1, 35);
        step(6);
        mark();
        clr = 7'h10;
        expect_at(0, 7'h00, 7'h00, 3'd4, 1'b1, 36);
        expect_at(1, 7'h00, 7'h00, 3'd4, 1'b0, 37);
        step(1);
        clr = 7'h00;
        step(3);
        mark();
        srci = 7'h10;
        expect_at(6, 7'h10, 7'h00, 3'd4, 1'b0, 38);
        expect_at(7, 7'h10, 7'h10, 3'd4, 1'b1, 39);
        expect_at(8, 7'h10, 7'h10, 3'd4, 1'b1, 40);
        step(7);
        clr = 7'h10;
        step(1);
        clr = 7'h00;
        step(3);

        // Ch1 and ch5 together, then ch3 later: first stays 1.
        do_reset(50);
        mark();
        srci = 7'h22;
        expect_at(6, 7'h22, 7'h00, 3'd0, 1'b0, 51);
        expect_at(7, 7'h22, 7'h22, 3'd1, 1'b1, 52);
        step(10);
        srci = 7'h2A;
        expect_at(16, 7'h2A, 7'h22, 3'd1, 1'b1, 53);
        expect_at(17, 7'h2A, 7'h2A, 3'd1, 1'b1, 54);
        step(9);

        // Ch6 active-low, then disabled.
        do_reset(60);
        mark();
        pol = 7'h40;
        expect_at(3, 7'h00, 7'h00, 3'd0, 1'b0, 61);
        expect_at(4, 7'h40, 7'h00, 3'd0, 1'b0, 62);
        expect_at(5, 7'h40, 7'h40, 3'd6, 1'b1, 63);
        step(7);
        mark();
        en = 7'h3F;
        expect_at(0, 7'h00, 7'h00, 3'd6, 1'b1, 64);
        expect_at(1, 7'h00, 7'h00, 3'd6, 1'b0, 65);
        step(3);

        // Sparse tick, thr_a=2: assertion on the third tick.
        do_reset(70);
        tick_all = 1'b0; ph = 0; thr_a = 8'd2;
        mark();
        srci = 7'h01;
        expect_at(10, 7'h00, 7'h00, 3'd0, 1'b0, 71);
        expect_at(11, 7'h01, 7'h00, 3'd0, 1'b0, 72);
        expect_at(12, 7'h01, 7'h01, 3'd0, 1'b1, 73);
        step(14);

        // Reset mid-count discards the partial count.
        do_reset(80);
        tick_all = 1'b0; ph = 0; thr_a = 8'd2;
        mark();
        srci = 7'h01;
        expect_at(9,  7'h00, 7'h00, 3'd0, 1'b0, 81);
        expect_at(22, 7'h00, 7'h00, 3'd0, 1'b0, 82);
        expect_at(23, 7'h01, 7'h00, 3'd0, 1'b0, 83);
        expect_at(24, 7'h01, 7'h01, 3'd0, 1'b1, 84);
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(17);

        step(2);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL chk%0d never reached (due cycle %0d, now %0d)", e.id, e.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
